// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// master = sequencer side, slave = host/ALU side.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_x;
    logic [3:0] rsp_y;
    logic [3:0] rsp_opcode;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_x, rsp_y, rsp_opcode
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_x, rsp_y, rsp_opcode
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Drives registered operands onto a combinational ALU, waits SETTLE cycles,
// then returns the opcode-masked x/y result over a valid/ready response.
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_sequencer_if.master   bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           r_state;
    logic [3:0]       r_settle_cnt;
    logic             r_cmd_ready;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [3:0]       r_alu_opcode;
    logic             r_rsp_valid;
    logic [3:0]       r_rsp_x;
    logic [3:0]       r_rsp_y;
    logic [3:0]       r_rsp_opcode;
    logic [CNT_W-1:0] r_done_count;

    logic [3:0]       w_x_mask;
    logic [3:0]       w_y_mask;

    // The ALU leaves bits it does not define stale; keep only the defined ones.
    always_comb begin
        w_x_mask = 4'b0001;
        w_y_mask = '0;
        case (r_alu_opcode)
            4'h3, 4'h4, 4'h5, 4'hA, 4'hB,
            4'hC, 4'hD, 4'hE, 4'hF:       w_x_mask = '1;
            default:                      w_x_mask = 4'b0001;
        endcase
        case (r_alu_opcode)
            4'hC, 4'hD, 4'hE:             w_y_mask = '1;
            4'hA:                         w_y_mask = 4'b0001;
            default:                      w_y_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_settle_cnt <= '0;
            r_cmd_ready  <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_opcode <= '0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_alu_a      <= bus.cmd_a;
                        r_alu_b      <= bus.cmd_b;
                        r_alu_opcode <= bus.cmd_opcode;
                        r_settle_cnt <= '0;
                        r_cmd_ready  <= 1'b0;
                        r_state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_rsp_x      <= bus.alu_x & w_x_mask;
                        r_rsp_y      <= bus.alu_y & w_y_mask;
                        r_rsp_opcode <= r_alu_opcode;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_done_count <= r_done_count + 1'b1;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_x      = r_rsp_x;
    assign bus.rsp_y      = r_rsp_y;
    assign bus.rsp_opcode = r_rsp_opcode;
    assign busy           = ~r_cmd_ready;
    assign done_count     = r_done_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: SETTLE=1/CNT_W=8 instance for function, masking and
// backpressure; SETTLE=3/CNT_W=2 instance for latency and counter wrap.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy_a, busy_b;
    logic [7:0] done_a;
    logic [1:0] done_b;
    logic [3:0] ovr_x, ovr_y;
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_done_a = 0;
    int         exp_done_b = 0;

    logic [3:0] b_op [4] = '{4'h3, 4'hA, 4'hC, 4'hC};
    logic [3:0] b_a  [4] = '{4'h5, 4'h9, 4'h3, 4'h4};
    logic [3:0] b_b  [4] = '{4'h3, 4'h8, 4'h5, 4'h4};
    logic [3:0] b_ex [4] = '{4'h1, 4'h1, 4'hF, 4'h0};
    logic [3:0] b_ey [4] = '{4'h0, 4'h1, 4'h0, 4'h1};

    always #5 clk = ~clk;

    alu_cmd_sequencer_if ia ();
    alu_cmd_sequencer_if ib ();

    alu_cmd_sequencer #(.SETTLE(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.master), .busy(busy_a), .done_count(done_a)
    );
    alu_cmd_sequencer #(.SETTLE(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.master), .busy(busy_b), .done_count(done_b)
    );

    // ALU model: undefined result bits come back deliberately non-zero (stale).
    function automatic logic [7:0] alu_model(input logic [3:0] op, a, b, ovx, ovy);
        logic [7:0] r;
        case (op)
            4'h3:    r = {4'hF, a & b};
            4'hA:    begin r[4:0] = {1'b0, a} + {1'b0, b}; r[7:5] = 3'b111; end
            4'hC:    r = {4'h0, a} * {4'h0, b};
            default: r = {ovy, ovx};
        endcase
        return r;
    endfunction

    assign {ia.alu_y, ia.alu_x} = alu_model(ia.alu_opcode, ia.alu_a, ia.alu_b, ovr_x, ovr_y);
    assign {ib.alu_y, ib.alu_x} = alu_model(ib.alu_opcode, ib.alu_a, ib.alu_b, ovr_x, ovr_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_a(input string tag, input logic [3:0] op, a, b, ex, ey, input logic hold_ready);
        chk({tag, ".cmd_ready_pre"}, 32'(ia.cmd_ready), 32'd1);
        ia.cmd_valid  = 1'b1;
        ia.cmd_opcode = op;
        ia.cmd_a      = a;
        ia.cmd_b      = b;
        ia.rsp_ready  = hold_ready;
        tick();
        ia.cmd_valid = 1'b0;
        chk({tag, ".alu_a"},      32'(ia.alu_a), 32'(a));
        chk({tag, ".alu_b"},      32'(ia.alu_b), 32'(b));
        chk({tag, ".alu_opcode"}, 32'(ia.alu_opcode), 32'(op));
        chk({tag, ".busy"},       32'(busy_a), 32'd1);
        chk({tag, ".rsp_valid0"}, 32'(ia.rsp_valid), 32'd0);
        tick();
        chk({tag, ".rsp_valid1"}, 32'(ia.rsp_valid), 32'd1);
        chk({tag, ".rsp_x"},      32'(ia.rsp_x), 32'(ex));
        chk({tag, ".rsp_y"},      32'(ia.rsp_y), 32'(ey));
        chk({tag, ".rsp_opcode"}, 32'(ia.rsp_opcode), 32'(op));
        chk({tag, ".done_held"},  32'(done_a), 32'(exp_done_a));
        ia.rsp_ready = 1'b1;
        tick();
        ia.rsp_ready = 1'b0;
        exp_done_a++;
        chk({tag, ".rsp_valid_clr"}, 32'(ia.rsp_valid), 32'd0);
        chk({tag, ".done"},          32'(done_a), 32'(exp_done_a));
        chk({tag, ".cmd_ready"},     32'(ia.cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ovr_x = '0;
        ovr_y = '0;
        ia.cmd_valid = 1'b0; ia.cmd_opcode = '0; ia.cmd_a = '0; ia.cmd_b = '0; ia.rsp_ready = 1'b0;
        ib.cmd_valid = 1'b0; ib.cmd_opcode = '0; ib.cmd_a = '0; ib.cmd_b = '0; ib.rsp_ready = 1'b0;
        repeat (2) tick();

        chk("rst.cmd_ready",  32'(ia.cmd_ready), 32'd1);
        chk("rst.busy",       32'(busy_a), 32'd0);
        chk("rst.rsp_valid",  32'(ia.rsp_valid), 32'd0);
        chk("rst.done",       32'(done_a), 32'd0);
        chk("rst.alu_a",      32'(ia.alu_a), 32'd0);
        chk("rst.alu_b",      32'(ia.alu_b), 32'd0);
        chk("rst.alu_opcode", 32'(ia.alu_opcode), 32'd0);
        chk("rst.rsp_x",      32'(ia.rsp_x), 32'd0);
        chk("rst.rsp_y",      32'(ia.rsp_y), 32'd0);
        chk("rst.rsp_opcode", 32'(ia.rsp_opcode), 32'd0);
        chk("rstb.cmd_ready", 32'(ib.cmd_ready), 32'd1);
        chk("rstb.done",      32'(done_b), 32'd0);
        rst_n = 1'b1;
        tick();

        run_a("and",  4'h3, 4'hC, 4'hA, 4'h8, 4'h0, 1'b0);
        run_a("addc", 4'hA, 4'hF, 4'h1, 4'h0, 4'h1, 1'b0);
        run_a("mul",  4'hC, 4'hF, 4'hF, 4'h1, 4'hE, 1'b0);
        ovr_x = 4'hE; ovr_y = 4'hF;
        run_a("mask_e", 4'h6, 4'h3, 4'h2, 4'h0, 4'h0, 1'b0);
        ovr_x = 4'hF;
        run_a("mask_f", 4'h6, 4'h3, 4'h2, 4'h1, 4'h0, 1'b0);
        ovr_x = '0; ovr_y = '0;
        run_a("rdy_early", 4'hC, 4'h2, 4'h3, 4'h6, 4'h0, 1'b1);

        // Backpressure with a competing command pending
        ia.cmd_valid = 1'b1; ia.cmd_opcode = 4'h3; ia.cmd_a = 4'hF; ia.cmd_b = 4'hF;
        tick();
        ia.cmd_valid = 1'b0;
        tick();
        chk("bp.rsp_valid", 32'(ia.rsp_valid), 32'd1);
        ia.cmd_valid = 1'b1; ia.cmd_opcode = 4'hC; ia.cmd_a = 4'h1; ia.cmd_b = 4'h2;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp%0d.rsp_valid", k),  32'(ia.rsp_valid), 32'd1);
            chk($sformatf("bp%0d.rsp_x", k),      32'(ia.rsp_x), 32'hF);
            chk($sformatf("bp%0d.rsp_opcode", k), 32'(ia.rsp_opcode), 32'h3);
            chk($sformatf("bp%0d.cmd_ready", k),  32'(ia.cmd_ready), 32'd0);
            chk($sformatf("bp%0d.alu_a", k),      32'(ia.alu_a), 32'hF);
            chk($sformatf("bp%0d.done", k),       32'(done_a), 32'(exp_done_a));
        end
        ia.cmd_valid = 1'b0;
        ia.rsp_ready = 1'b1;
        tick();
        ia.rsp_ready = 1'b0;
        exp_done_a++;
        chk("bp.rel.done",      32'(done_a), 32'(exp_done_a));
        chk("bp.rel.cmd_ready", 32'(ia.cmd_ready), 32'd1);
        chk("bp.rel.rsp_valid", 32'(ia.rsp_valid), 32'd0);

        // SETTLE=3 latency, CNT_W=2 wrap
        for (int i = 0; i < 4; i++) begin
            ib.cmd_valid = 1'b1; ib.cmd_opcode = b_op[i]; ib.cmd_a = b_a[i]; ib.cmd_b = b_b[i];
            tick();
            ib.cmd_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("lat%0d.%0d.alu_a", i, k),      32'(ib.alu_a), 32'(b_a[i]));
                chk($sformatf("lat%0d.%0d.alu_opcode", i, k), 32'(ib.alu_opcode), 32'(b_op[i]));
                chk($sformatf("lat%0d.%0d.rsp_valid", i, k),  32'(ib.rsp_valid), 32'd0);
                tick();
            end
            chk($sformatf("lat%0d.rsp_valid", i), 32'(ib.rsp_valid), 32'd1);
            chk($sformatf("lat%0d.alu_b", i),     32'(ib.alu_b), 32'(b_b[i]));
            chk($sformatf("lat%0d.rsp_x", i),     32'(ib.rsp_x), 32'(b_ex[i]));
            chk($sformatf("lat%0d.rsp_y", i),     32'(ib.rsp_y), 32'(b_ey[i]));
            ib.rsp_ready = 1'b1;
            tick();
            ib.rsp_ready = 1'b0;
            exp_done_b = (exp_done_b + 1) % 4;
            chk($sformatf("lat%0d.done", i), 32'(done_b), 32'(exp_done_b));
        end
        chk("wrap.done_zero", 32'(done_b), 32'd0);

        // Reset while in DRIVE drops the command
        ia.cmd_valid = 1'b1; ia.cmd_opcode = 4'h5; ia.cmd_a = 4'h7; ia.cmd_b = 4'h7;
        tick();
        ia.cmd_valid = 1'b0;
        chk("rdrv.busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rdrv.rsp_valid", 32'(ia.rsp_valid), 32'd0);
        chk("rdrv.done",      32'(done_a), 32'd0);
        chk("rdrv.cmd_ready", 32'(ia.cmd_ready), 32'd1);
        chk("rdrv.busy",      32'(busy_a), 32'd0);
        chk("rdrv.alu_a",     32'(ia.alu_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rdrv.idle.cmd_ready", 32'(ia.cmd_ready), 32'd1);
        chk("rdrv.idle.rsp_valid", 32'(ia.rsp_valid), 32'd0);
        tick();
        chk("rdrv.dropped", 32'(ia.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
